// File: rtl/adder_tree_pkg.sv
// Shared widths and limits for the pipelined adder tree.
// ADDER_TREE_ACCUM_EN adds the multi-beat accumulator width to the output.
package adder_tree_pkg;

    localparam int MAX_LEVELS = 6;

`ifdef ADDER_TREE_ACCUM_EN
    localparam bit ACCUM_EN = 1'b1;
`else
    localparam bit ACCUM_EN = 1'b0;
`endif

    function automatic int lvl_width(int width, int k);
        return width + k;
    endfunction

    function automatic int out_width(int width, int levels, int acc_bits);
        return width + levels + (ACCUM_EN ? acc_bits : 0);
    endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One tree level: registered pairwise sums of 2*PAIRS operands, one bit wider each.
module adder_tree_stage
    import adder_tree_pkg::*;
#(
    parameter int IN_W  = 19,
    parameter int PAIRS = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            in_vld,
    input  logic [2*PAIRS*IN_W-1:0]         in_data,
    output logic                            out_vld,
    output logic [PAIRS*lvl_width(IN_W,1)-1:0] out_data
);

    localparam int SW = lvl_width(IN_W, 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (en) begin
            out_vld <= in_vld;
            for (int p = 0; p < PAIRS; p++) begin
                out_data[p*SW +: SW] <= SW'(in_data[2*p*IN_W +: IN_W])
                                      + SW'(in_data[(2*p+1)*IN_W +: IN_W]);
            end
        end
    end

endmodule

// File: rtl/adder_tree_pipe.sv
// Fully pipelined 2**LEVELS-operand adder tree with global-stall backpressure.
// ADDER_TREE_ACCUM_EN adds a post-tree accumulator emitting one sum per in_last frame.
module adder_tree_pipe
    import adder_tree_pkg::*;
#(
    parameter int WIDTH    = 19,
    parameter int LEVELS   = 3,
    parameter int ACC_BITS = 8,
    localparam int N       = 1 << LEVELS,
    localparam int OW      = out_width(WIDTH, LEVELS, ACC_BITS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] in_data,
`ifdef ADDER_TREE_ACCUM_EN
    input  logic               in_last,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OW-1:0]      out_sum
);

    localparam int TW = lvl_width(WIDTH, LEVELS);

    // Bit offset of level k's sums inside the flat tree bus (levels 1..LEVELS).
    function automatic int lvl_off(int k);
        int o = 0;
        for (int j = 1; j < k; j++) o += (N >> j) * lvl_width(WIDTH, j);
        return o;
    endfunction

    logic                       adv;
    logic [LEVELS:0]            vld_pipe;
    logic                       vld0;
    logic [N*WIDTH-1:0]         data0;
    logic [lvl_off(LEVELS+1)-1:0] tree;
    logic [TW-1:0]              tree_sum;

    // Whole pipe moves as one; bubbles shift so latency is fixed.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld0  <= 1'b0;
            data0 <= '0;
        end else if (adv) begin
            vld0  <= in_valid;
            data0 <= in_data;
        end
    end

    assign vld_pipe[0] = vld0;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int IW = lvl_width(WIDTH, k-1);
        localparam int P  = N >> k;
        logic [2*P*IW-1:0] din;

        if (k == 1) begin : g_first
            assign din = data0;
        end else begin : g_next
            assign din = tree[lvl_off(k-1) +: 2*P*IW];
        end

        adder_tree_stage #(.IN_W(IW), .PAIRS(P)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (adv),
            .in_vld   (vld_pipe[k-1]),
            .in_data  (din),
            .out_vld  (vld_pipe[k]),
            .out_data (tree[lvl_off(k) +: P*(IW+1)])
        );
    end

    assign tree_sum = tree[lvl_off(LEVELS) +: TW];

`ifdef ADDER_TREE_ACCUM_EN
    logic [LEVELS:0] last_pipe;
    logic [OW-1:0]   acc;
    logic [OW-1:0]   acc_nxt;

    assign acc_nxt = acc + OW'(tree_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pipe <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else if (adv) begin
            last_pipe <= {last_pipe[LEVELS-1:0], in_last};
            out_valid <= vld_pipe[LEVELS] && last_pipe[LEVELS];
            if (vld_pipe[LEVELS]) begin
                if (last_pipe[LEVELS]) begin
                    out_sum <= acc_nxt;
                    acc     <= '0;
                end else begin
                    acc     <= acc_nxt;
                end
            end
        end
    end
`else
    assign out_valid = vld_pipe[LEVELS];
    assign out_sum   = tree_sum;
`endif

endmodule
